uart_tx: RTL and testbench

UART transmitter: the send side of the serial link whose receive front end samples `rx` on the team's UART receiver. Accepts a parallel byte via a valid/ready handshake and shifts it out as an asynchronous frame: start bit, data LSB first, stop bit(s). It runs on the system clock and times each bit with an internal clock-enable counter, so no second clock domain is needed.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_tx.sv | 115 +++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: state encoding,
// default bit timing and the line levels of an asynchronous frame.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 8;

   localparam logic UART_IDLE_LEVEL = 1'b1;
   localparam logic START_LEVEL     = 1'b0;
   localparam logic STOP_LEVEL      = 1'b1;

   // Total system clocks occupied by one frame on the line.
   function automatic int frame_cycles(input int clks_per_bit,
                                       input int data_bits,
                                       input int stop_bits);
      return clks_per_bit * (1 + data_bits + stop_bits);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period clock-enable: counts system clocks and flags the last clock of
// every serial bit so the FSM can advance on exact bit boundaries.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] clk_cnt;

   // Wraps on its own at the bit boundary; clear re-aligns it to a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_cnt <= '0;
      end else if (clear || (clk_cnt == LAST_CNT)) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + 1'b1;
      end
   end

   assign bit_done = (clk_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: takes a word over a valid/ready handshake and shifts it
// out as start bit, data LSB first, then one or two stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   uart_state_t          state;
   logic [DATA_BITS-1:0] shift_reg;
   logic [BW-1:0]        bit_cnt;
   logic                 bit_done;
   logic                 last_stop;
   logic                 handshake;
   logic                 timer_clear;

   // Ready in the final stop clock lets a new frame start with no idle gap.
   assign last_stop   = (state == STOP) && bit_done && (bit_cnt == LAST_STOP);
   assign tx_ready    = (state == IDLE) || last_stop;
   assign handshake   = tx_valid && tx_ready;
   assign busy        = (state != IDLE);
   assign timer_clear = handshake || (state == IDLE);

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .bit_done(bit_done)
   );

   // tx is loaded with the level of the state being entered, keeping it a
   // pure register output aligned with the state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tx        <= UART_IDLE_LEVEL;
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= UART_IDLE_LEVEL;
               if (handshake) begin
                  shift_reg <= tx_data;
                  bit_cnt   <= '0;
                  state     <= START;
                  tx        <= START_LEVEL;
               end
            end

            START: begin
               if (bit_done) begin
                  bit_cnt <= '0;
                  state   <= DATA;
                  tx      <= shift_reg[0];
               end
            end

            DATA: begin
               if (bit_done) begin
                  shift_reg <= shift_reg >> 1;
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= STOP;
                     tx      <= STOP_LEVEL;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     tx      <= shift_reg[1];
                  end
               end
            end

            STOP: begin
               if (bit_done) begin
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     if (handshake) begin
                        shift_reg <= tx_data;
                        state     <= START;
                        tx        <= START_LEVEL;
                     end else begin
                        state <= IDLE;
                        tx    <= UART_IDLE_LEVEL;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               tx    <= UART_IDLE_LEVEL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a default-parameter instance and a
// 3-clock / 7-data / 2-stop instance, each decoded by a line-level monitor.
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data_a;
   logic       tx_valid_a, tx_ready_a, tx_a, busy_a;
   logic [6:0] tx_data_b;
   logic       tx_valid_b, tx_ready_b, tx_b, busy_b;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int exp_a[$];
   int exp_b[$];
   int starts_a[$];
   int starts_b[$];
   int frames_a = 0;
   int frames_b = 0;
   bit mon_en_a = 1'b1;
   bit mon_en_b = 1'b1;

   uart_tx dut_a (
      .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
      .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a)
   );

   uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
      .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Offers one word; returns 1 ns after the accepting edge (frame cycle 0).
   task automatic applyStimulus(input int sel, input int d, input bit hold, input bit push);
      int n = 0;
      if (sel == 1) begin
         tx_data_b = 7'(d);
         tx_valid_b = 1'b1;
      end else begin
         tx_data_a = 8'(d);
         tx_valid_a = 1'b1;
      end
      while (!((sel == 1) ? tx_ready_b : tx_ready_a) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) checkOutput("ready_wait_timeout", n, 0);
      if (push) begin
         if (sel == 1) exp_b.push_back(d & 'h7F);
         else exp_a.push_back(d & 'hFF);
      end
      @(posedge clk); #1;
      if (!hold) begin
         if (sel == 1) tx_valid_b = 1'b0;
         else tx_valid_a = 1'b0;
      end
   endtask

   task automatic wait_idle(input int sel);
      int n = 0;
      @(negedge clk);
      while (((sel == 1) ? busy_b : busy_a) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) checkOutput("idle_wait_timeout", n, 0);
      @(posedge clk); #1;
   endtask

   // Counts busy clocks from frame cycle 0, then checks the first idle cycle.
   task automatic measure_frame(input int sel, input int frame_len);
      int n = 0;
      while (((sel == 1) ? busy_b : busy_a) && n < 500) begin
         n++;
         @(posedge clk); #1;
      end
      checkOutput("busy_cycles", n, frame_len);
      checkOutput("ready_first_idle", int'((sel == 1) ? tx_ready_b : tx_ready_a), 1);
      checkOutput("tx_first_idle", int'((sel == 1) ? tx_b : tx_a), 1);
   endtask

   // Reference receiver: captures a whole frame from its falling start edge,
   // decodes it at mid-bit and compares every clock with the ideal waveform.
   task automatic monitor(input int sel);
      int cpb, db, sb, flen, expv, got, start, err_line, err_busy, err_rdy;
      bit [127:0] s_tx, s_busy, s_rdy;
      bit aborted, want;
      cpb = (sel == 1) ? 3 : 8;
      db  = (sel == 1) ? 7 : 8;
      sb  = (sel == 1) ? 2 : 1;
      flen = cpb * (1 + db + sb);
      forever begin
         @(negedge clk);
         if (rst || !((sel == 1) ? mon_en_b : mon_en_a)) continue;
         if (((sel == 1) ? tx_b : tx_a) !== 1'b0) continue;
         start = cyc;
         aborted = 1'b0;
         for (int k = 0; k < flen; k++) begin
            if (k > 0) @(negedge clk);
            if (rst) aborted = 1'b1;
            s_tx[k]   = (sel == 1) ? tx_b : tx_a;
            s_busy[k] = (sel == 1) ? busy_b : busy_a;
            s_rdy[k]  = (sel == 1) ? tx_ready_b : tx_ready_a;
         end
         if (aborted) continue;
         if (sel == 1) begin
            starts_b.push_back(start);
            frames_b++;
         end else begin
            starts_a.push_back(start);
            frames_a++;
         end
         if (((sel == 1) ? exp_b.size() : exp_a.size()) == 0) begin
            checkOutput("unexpected_frame_queue", 0, 1);
            continue;
         end
         expv = (sel == 1) ? exp_b.pop_front() : exp_a.pop_front();
         got = 0;
         for (int i = 0; i < db; i++) got |= int'(s_tx[(1 + i) * cpb + cpb / 2]) << i;
         err_line = 0;
         err_busy = 0;
         err_rdy = 0;
         for (int k = 0; k < flen; k++) begin
            int b = k / cpb;
            if (b == 0) want = 1'b0;
            else if (b <= db) want = 1'((expv >> (b - 1)) & 1);
            else want = 1'b1;
            if (s_tx[k] != want) err_line++;
            if (s_busy[k] != 1'b1) err_busy++;
            if (s_rdy[k] != (k == flen - 1)) err_rdy++;
         end
         checkOutput((sel == 1) ? "frame_data_b" : "frame_data_a", got, expv);
         checkOutput((sel == 1) ? "waveform_errs_b" : "waveform_errs_a", err_line, 0);
         checkOutput((sel == 1) ? "busy_errs_b" : "busy_errs_a", err_busy, 0);
         checkOutput((sel == 1) ? "ready_errs_b" : "ready_errs_a", err_rdy, 0);
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int errs, f0, b2b;
      rst = 1'b1;
      tx_valid_a = 1'b0; tx_data_a = '0;
      tx_valid_b = 1'b0; tx_data_b = '0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state and a quiet idle line.
      @(negedge clk);
      checkOutput("reset_tx_a", int'(tx_a), 1);
      checkOutput("reset_busy_a", int'(busy_a), 0);
      checkOutput("reset_ready_a", int'(tx_ready_a), 1);
      checkOutput("reset_tx_b", int'(tx_b), 1);
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || tx_b !== 1'b1) errs++;
      end
      checkOutput("idle_line_errs", errs, 0);
      @(posedge clk); #1;

      // Single 0xA5 frame.
      applyStimulus(0, 'hA5, 0, 1);
      measure_frame(0, 80);

      // Back-to-back 0x00 then 0xFF with valid held high.
      starts_a.delete();
      applyStimulus(0, 'h00, 1, 1);
      applyStimulus(0, 'hFF, 0, 1);
      wait_idle(0);
      checkOutput("b2b_frame_count", starts_a.size(), 2);
      b2b = (starts_a.size() == 2) ? starts_a[1] - starts_a[0] : -1;
      checkOutput("b2b_start_spacing", b2b, 80);

      // Valid pulsed mid-frame must be dropped.
      f0 = frames_a;
      applyStimulus(0, 'h55, 0, 1);
      repeat (20) @(posedge clk);
      #1;
      tx_data_a = 8'h3C; tx_valid_a = 1'b1;
      @(posedge clk); #1;
      tx_valid_a = 1'b0;
      wait_idle(0);
      repeat (100) @(posedge clk);
      #1;
      checkOutput("ignored_valid_frames", frames_a - f0, 1);
      checkOutput("ignored_valid_busy", int'(busy_a), 0);

      // Asynchronous reset during data bit 3 of 0x0F.
      mon_en_a = 1'b0;
      applyStimulus(0, 'h0F, 0, 0);
      repeat (34) @(posedge clk);
      #1;
      checkOutput("midreset_busy_before", int'(busy_a), 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("midreset_tx", int'(tx_a), 1);
      checkOutput("midreset_busy", int'(busy_a), 0);
      checkOutput("midreset_ready", int'(tx_ready_a), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en_a = 1'b1;
      applyStimulus(0, 'h81, 0, 1);
      measure_frame(0, 80);

      // Narrow instance: 7 data bits, 2 stop bits, 3 clocks per bit.
      applyStimulus(1, 'h41, 0, 1);
      measure_frame(1, 30);

      // Randomised traffic on both instances.
      for (int i = 0; i < 20; i++) begin
         bit hold = (i != 19) && ($urandom_range(0, 1) == 1);
         applyStimulus(0, int'($urandom_range(0, 255)), hold, 1);
         if (!hold) repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
      end
      wait_idle(0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, int'($urandom_range(0, 127)), 0, 1);
         repeat ($urandom_range(0, 40)) @(posedge clk);
         #1;
      end
      wait_idle(1);
      repeat (5) @(posedge clk);

      checkOutput("queue_drained_a", exp_a.size(), 0);
      checkOutput("queue_drained_b", exp_b.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
